// File: rtl/spi_reg_responder_if.sv
// spi_reg_responder_if
//   Bundles the serial frame signals and the debug read port of the SPI
//   register responder.
//   Ports / signals:
//     cs        - chip select, active low, frames a transfer
//     mosi      - serial data from the initiator, MSB first
//     miso      - serial data back to the initiator, MSB first
//     done      - one-cycle pulse at the end of a complete frame
//     wr_strobe - one-cycle pulse when a register has been written
//     dbg_addr  - debug read address
//     dbg_data  - combinational contents of the addressed register
//   Modports: master = initiator / bench side, slave = responder side.
interface spi_reg_responder_if #(
  parameter int DATA_W = 8
);
  logic              cs;
  logic              mosi;
  logic              miso;
  logic              done;
  logic              wr_strobe;
  logic [3:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output cs, mosi, dbg_addr,
    input  miso, done, wr_strobe, dbg_data
  );

  modport slave (
    input  cs, mosi, dbg_addr,
    output miso, done, wr_strobe, dbg_data
  );
endinterface

// File: rtl/spi_reg_responder.sv
// spi_reg_responder
//   Far end of the processor's SPI initiator, clocked by the system clock.
//   A frame is an 8-bit command (bit7 = write, bits 6:3 = address) followed
//   by a DATA_W-bit data phase. Writes land in a small register file; reads
//   shift the addressed register back on miso. cs high mid-frame aborts.
//   Ports:
//     clk - system clock, rising edge
//     rst - asynchronous active-high reset (clears the register file too)
//     bus - spi_reg_responder_if.slave (cs, mosi, miso, done, wr_strobe,
//           dbg_addr, dbg_data)
module spi_reg_responder #(
  parameter int nRegisters = 16,
  parameter int DATA_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_reg_responder_if.slave   bus
);

  localparam int CW = (DATA_W > 8) ? $clog2(DATA_W) : 3;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_DATA,
    RD_DATA,
    HOLD
  } state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic [6:0]        cmd_sr, cmd_next;
  logic [3:0]        addr, addr_next;
  logic [DATA_W-1:0] shreg, sr_next;
  logic              miso_next, done_next, wr_next;
  logic              reg_we;
  logic [DATA_W-1:0] cmd_rd_word;

  logic [DATA_W-1:0] regs [nRegisters];

  // Register-file read for the address still sitting in the command shift
  // register; used on the last command edge to preload the read data.
  always_comb begin
    cmd_rd_word = '0;
    if ({1'b0, cmd_sr[5:2]} < 5'(nRegisters))
      cmd_rd_word = regs[cmd_sr[5:2]];
  end

  // Debug port: out-of-range addresses read as zero.
  always_comb begin
    bus.dbg_data = '0;
    if ({1'b0, bus.dbg_addr} < 5'(nRegisters))
      bus.dbg_data = regs[bus.dbg_addr];
  end

  // Next-state and next-output logic. miso defaults to 0 so it is only ever
  // driven with data while the read phase is active; cs high in any active
  // phase returns to IDLE without touching the register file.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cmd_next   = cmd_sr;
    addr_next  = addr;
    sr_next    = shreg;
    miso_next  = 1'b0;
    done_next  = 1'b0;
    wr_next    = 1'b0;
    reg_we     = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.cs) begin
          cmd_next   = {6'b0, bus.mosi};
          cnt_next   = CW'(1);
          state_next = CMD;
        end
      end
      CMD: begin
        if (bus.cs) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cmd_next = {cmd_sr[5:0], bus.mosi};
          cnt_next = cnt + CW'(1);
          if (cnt == CW'(7)) begin
            // cmd_sr holds command bits 7..1 here; bit0 is don't-care.
            addr_next = cmd_sr[5:2];
            cnt_next  = '0;
            if (cmd_sr[6]) begin
              state_next = WR_DATA;
            end else begin
              state_next = RD_DATA;
              sr_next    = cmd_rd_word;
              miso_next  = cmd_rd_word[DATA_W-1];
            end
          end
        end
      end
      WR_DATA: begin
        if (bus.cs) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          sr_next  = {shreg[DATA_W-2:0], bus.mosi};
          cnt_next = cnt + CW'(1);
          if (cnt == CW'(DATA_W-1)) begin
            reg_we     = ({1'b0, addr} < 5'(nRegisters));
            wr_next    = 1'b1;
            done_next  = 1'b1;
            cnt_next   = '0;
            state_next = HOLD;
          end
        end
      end
      RD_DATA: begin
        if (bus.cs) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CW'(DATA_W-1)) begin
          done_next  = 1'b1;
          cnt_next   = '0;
          state_next = HOLD;
        end else begin
          // miso already shows shreg MSB; present the next bit down.
          sr_next   = {shreg[DATA_W-2:0], 1'b0};
          miso_next = shreg[DATA_W-2];
          cnt_next  = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (bus.cs)
          state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counters, shift registers and the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      cmd_sr        <= '0;
      addr          <= '0;
      shreg         <= '0;
      bus.miso      <= 1'b0;
      bus.done      <= 1'b0;
      bus.wr_strobe <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      cmd_sr        <= cmd_next;
      addr          <= addr_next;
      shreg         <= sr_next;
      bus.miso      <= miso_next;
      bus.done      <= done_next;
      bus.wr_strobe <= wr_next;
    end
  end

  // Register file; written on the edge that samples the last data bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < nRegisters; i++)
        regs[i] <= '0;
    end else if (reg_we) begin
      regs[addr] <= sr_next;
    end
  end

endmodule

// File: tb/tb_spi_reg_responder.sv
// tb_spi_reg_responder
//   Self-checking bench for spi_reg_responder: directed frames plus a run of
//   random frames (random commands, data and aborts) compared against a
//   simple array model of the register file.
module tb_spi_reg_responder;

  logic clk;
  logic rst;
  int   nChecks;
  int   nFails;

  logic [7:0] model [16];

  spi_reg_responder_if #(.DATA_W(8)) bus ();

  spi_reg_responder #(
    .nRegisters(16),
    .DATA_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full frame. abortAt >= 0 raises cs on the edge that would sample
  // data bit number abortAt (0 = first data bit). extraLow keeps cs low for
  // that many cycles after the frame. Always ends with one cs-high cycle.
  task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] data,
                               input int abortAt, input int extraLow,
                               output logic [7:0] rdByte, output int nDone,
                               output int nWr, output int nMisoHigh);
    rdByte = '0;
    nDone = 0;
    nWr = 0;
    nMisoHigh = 0;
    for (int e = 0; e < 16; e++) begin
      if (abortAt >= 0 && e == 8 + abortAt) begin
        bus.cs = 1'b1;
        bus.mosi = 1'($urandom_range(0, 1));
        tick();
        nDone += int'(bus.done);
        nWr += int'(bus.wr_strobe);
        if (bus.miso) nMisoHigh++;
        break;
      end
      bus.cs = 1'b0;
      bus.mosi = (e < 8) ? cmd[7-e] : data[15-e];
      tick();
      if (!cmd[7] && e >= 7 && e <= 14) rdByte[14-e] = bus.miso;
      else if (bus.miso) nMisoHigh++;
      nDone += int'(bus.done);
      nWr += int'(bus.wr_strobe);
    end
    for (int k = 0; k < extraLow; k++) begin
      bus.cs = 1'b0;
      bus.mosi = 1'($urandom_range(0, 1));
      tick();
      nDone += int'(bus.done);
      nWr += int'(bus.wr_strobe);
      if (bus.miso) nMisoHigh++;
    end
    bus.cs = 1'b1;
    bus.mosi = 1'b0;
    tick();
    nDone += int'(bus.done);
    nWr += int'(bus.wr_strobe);
    if (bus.miso) nMisoHigh++;
  endtask

  task automatic checkAllRegs(input string tag);
    for (int a = 0; a < 16; a++) begin
      bus.dbg_addr = 4'(a);
      #1;
      checkOutput($sformatf("%s_dbg%0d", tag, a), 32'(bus.dbg_data), 32'(model[a]));
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] cmd;
    logic [7:0] data;
    int nd, nw, nm, abortAt;
    bit isWrite;
    logic [3:0] a;

    nChecks = 0;
    nFails = 0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    bus.cs = 1'b1;
    bus.mosi = 1'b0;
    bus.dbg_addr = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    checkOutput("rst_miso", 32'(bus.miso), 0);
    checkOutput("rst_done", 32'(bus.done), 0);
    checkOutput("rst_wr", 32'(bus.wr_strobe), 0);
    checkAllRegs("rst");

    // Read of an untouched register.
    applyStimulus(8'h28, 8'h00, -1, 0, rd, nd, nw, nm);
    checkOutput("rd5_data", 32'(rd), 0);
    checkOutput("rd5_done", 32'(nd), 1);
    checkOutput("rd5_wr", 32'(nw), 0);

    // Write then read back addr 3.
    applyStimulus(8'h98, 8'hA5, -1, 0, rd, nd, nw, nm);
    model[3] = 8'hA5;
    checkOutput("wr3_done", 32'(nd), 1);
    checkOutput("wr3_wr", 32'(nw), 1);
    checkOutput("wr3_miso", 32'(nm), 0);
    bus.dbg_addr = 4'd3;
    #1;
    checkOutput("wr3_dbg", 32'(bus.dbg_data), 32'h A5);
    applyStimulus(8'h18, 8'h00, -1, 0, rd, nd, nw, nm);
    checkOutput("rd3_data", 32'(rd), 32'hA5);
    checkOutput("rd3_done", 32'(nd), 1);

    // Aborted write after 4 data bits, then a normal read.
    applyStimulus(8'hB8, 8'h3C, 4, 0, rd, nd, nw, nm);
    checkOutput("abort_done", 32'(nd), 0);
    checkOutput("abort_wr", 32'(nw), 0);
    bus.dbg_addr = 4'd7;
    #1;
    checkOutput("abort_dbg7", 32'(bus.dbg_data), 0);
    applyStimulus(8'h18, 8'h00, -1, 0, rd, nd, nw, nm);
    checkOutput("post_abort_rd3", 32'(rd), 32'hA5);

    // Back-to-back frames with a one-cycle cs-high gap.
    applyStimulus(8'h80, 8'h11, -1, 0, rd, nd, nw, nm);
    model[0] = 8'h11;
    applyStimulus(8'hF8, 8'hFF, -1, 0, rd, nd, nw, nm);
    model[15] = 8'hFF;
    applyStimulus(8'h00, 8'h00, -1, 0, rd, nd, nw, nm);
    checkOutput("b2b_rd0", 32'(rd), 32'h11);
    bus.dbg_addr = 4'd15;
    #1;
    checkOutput("b2b_dbg15", 32'(bus.dbg_data), 32'hFF);

    // Write followed by ten extra cs-low cycles with mosi toggling.
    applyStimulus(8'h90, 8'h5A, -1, 10, rd, nd, nw, nm);
    model[2] = 8'h5A;
    checkOutput("hold_done", 32'(nd), 1);
    checkOutput("hold_wr", 32'(nw), 1);
    checkOutput("hold_miso", 32'(nm), 0);
    checkAllRegs("hold");

    // Random frames against the array model.
    for (int n = 0; n < 40; n++) begin
      cmd = 8'($urandom);
      data = 8'($urandom);
      abortAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      isWrite = cmd[7];
      a = cmd[6:3];
      applyStimulus(cmd, data, abortAt, int'($urandom_range(0, 2)), rd, nd, nw, nm);
      checkOutput($sformatf("rnd%0d_done", n), 32'(nd), (abortAt < 0) ? 1 : 0);
      checkOutput($sformatf("rnd%0d_wr", n), 32'(nw), (abortAt < 0 && isWrite) ? 1 : 0);
      if (abortAt < 0 && isWrite) model[a] = data;
      if (abortAt < 0 && !isWrite)
        checkOutput($sformatf("rnd%0d_rd", n), 32'(rd), 32'(model[a]));
      if (isWrite) checkOutput($sformatf("rnd%0d_miso", n), 32'(nm), 0);
      bus.dbg_addr = 4'($urandom);
      #1;
      checkOutput($sformatf("rnd%0d_dbg", n), 32'(bus.dbg_data), 32'(model[bus.dbg_addr]));
    end

    // Reset in the middle of a read of an all-ones register.
    applyStimulus(8'hC8, 8'hFF, -1, 0, rd, nd, nw, nm);
    model[9] = 8'hFF;
    for (int e = 0; e < 12; e++) begin
      bus.cs = 1'b0;
      bus.mosi = (e < 8) ? 1'((8'h48 >> (7 - e)) & 8'h01) : 1'b0;
      tick();
    end
    checkOutput("prerst_miso", 32'(bus.miso), 1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_miso", 32'(bus.miso), 0);
    checkOutput("midrst_done", 32'(bus.done), 0);
    for (int i = 0; i < 16; i++) model[i] = '0;
    checkAllRegs("midrst");
    bus.cs = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(8'h48, 8'h00, -1, 0, rd, nd, nw, nm);
    checkOutput("postrst_rd9", 32'(rd), 0);
    checkOutput("postrst_done", 32'(nd), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
